// File: rtl/i2s_adc_rx_pkg.sv
// Shared audio definitions: receiver FSM states, I2S framing constants and
// the sign-extension helper used when a captured word is handed downstream.
package audio_pkg;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        SKIP,
        SHIFT,
        TAIL
    } i2s_rx_state_t;

    // Number of BCLK slots between the LRCK edge and the word MSB.
    localparam int I2S_MSB_DELAY = 1;
    localparam int SAMPLE_W      = 32;

    // Replicate bit [bits-1] into every position at or above 'bits'.
    function automatic logic [SAMPLE_W-1:0] sign_extend(input logic [SAMPLE_W-1:0] w,
                                                        input int bits);
        logic [SAMPLE_W-1:0] r;
        for (int i = 0; i < SAMPLE_W; i++) begin
            r[i] = (i < bits) ? w[i] : w[bits-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/i2s_adc_rx_if.sv
// Sample handshake between the I2S receiver (master) and the gain stage.
interface i2s_adc_rx_if;
    logic [31:0] sample;
    logic        READY;
    logic        GAIN_IDLE;

    modport master (output sample, output READY, input GAIN_IDLE);
    modport slave  (input sample, input READY, output GAIN_IDLE);
endinterface

// File: rtl/i2s_adc_rx_sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous pin, with registered edge
// pulses. 'level' is the delayed copy that lines up with rise/fall, so a
// consumer sees the new level in the same cycle as the edge pulse.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    // Synchroniser chain, then one more register stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign level = prev_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/i2s_adc_rx.sv
// I2S ADC receiver: captures one channel's MSB-first word per frame, holds
// at most one pending word, and hands it to the gain stage when it is idle.
module i2s_adc_rx
    import audio_pkg::*;
#(
    parameter int DATA_BITS   = 24,
    parameter int CHANNEL     = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        AUD_BCLK,
    input  logic        AUD_ADCLRCK,
    input  logic        AUD_ADCDAT,
    input  logic        CLR_OVERRUN,
    i2s_adc_rx_if.master gain,
    output logic        OVERRUN,
    output logic [15:0] frame_count
);

    localparam logic       CH_LVL   = (CHANNEL != 0);
    localparam logic [5:0] LAST_BIT = 6'(DATA_BITS);

    logic bclk_lvl, bclk_rise, bclk_fall;
    logic lrck_lvl, lrck_rise, lrck_fall;
    logic dat_lvl,  dat_rise,  dat_fall;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk(CLK), .rst_n(RESET_N), .d(AUD_BCLK),
        .level(bclk_lvl), .rise(bclk_rise), .fall(bclk_fall));
    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_lrck (
        .clk(CLK), .rst_n(RESET_N), .d(AUD_ADCLRCK),
        .level(lrck_lvl), .rise(lrck_rise), .fall(lrck_fall));
    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_dat (
        .clk(CLK), .rst_n(RESET_N), .d(AUD_ADCDAT),
        .level(dat_lvl), .rise(dat_rise), .fall(dat_fall));

    logic unused_sync;
    assign unused_sync = ^{bclk_lvl, bclk_fall, dat_rise, dat_fall};

    logic lrck_edge;
    assign lrck_edge = lrck_rise | lrck_fall;

    i2s_rx_state_t state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [31:0]   shreg_q, shreg_d;
    logic          complete;
    logic [31:0]   word_ext;

    logic          pend_q, pend_d;
    logic [31:0]   pword_q, pword_d;
    logic [31:0]   sample_q, sample_d;
    logic          ready_q, ready_d;
    logic          ovr_q, ovr_d;
    logic [15:0]   fcnt_q, fcnt_d;
    logic          deliver;

    // Frame FSM state, bit counter and shift register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= WAIT_FRAME;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // Next state; an LRCK edge overrides everything so a short frame is
    // dropped and the new frame boundary is still honoured this cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        complete = 1'b0;
        case (state_q)
            SKIP:  if (bclk_rise) state_d = SHIFT;
            SHIFT: if (bclk_rise) begin
                shreg_d = {shreg_q[30:0], dat_lvl};
                cnt_d   = cnt_q + 6'd1;
                if (cnt_d == LAST_BIT) begin
                    complete = 1'b1;
                    state_d  = TAIL;
                end
            end
            default: ;
        endcase
        if (lrck_edge) begin
            complete = 1'b0;
            cnt_d    = '0;
            state_d  = (lrck_lvl == CH_LVL) ? SKIP : WAIT_FRAME;
        end
    end

    assign word_ext = sign_extend(shreg_d, DATA_BITS);

    // Delivery and status registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pend_q   <= 1'b0;
            pword_q  <= '0;
            sample_q <= '0;
            ready_q  <= 1'b0;
            ovr_q    <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            pend_q   <= pend_d;
            pword_q  <= pword_d;
            sample_q <= sample_d;
            ready_q  <= ready_d;
            ovr_q    <= ovr_d;
            fcnt_q   <= fcnt_d;
        end
    end

    // Hand the pending word over when the gain stage is idle; the ready_q
    // guard keeps READY from firing on two consecutive cycles.
    always_comb begin
        deliver  = pend_q & gain.GAIN_IDLE & ~ready_q;
        ready_d  = deliver;
        sample_d = deliver ? pword_q : sample_q;
        fcnt_d   = deliver ? fcnt_q + 16'd1 : fcnt_q;
        pend_d   = complete | (pend_q & ~deliver);
        pword_d  = complete ? word_ext : pword_q;
        ovr_d    = ovr_q;
        if (CLR_OVERRUN) ovr_d = 1'b0;
        if (complete && pend_q && !deliver) ovr_d = 1'b1;
    end

    assign gain.sample = sample_q;
    assign gain.READY  = ready_q;
    assign OVERRUN     = ovr_q;
    assign frame_count = fcnt_q;

endmodule

// File: doc/i2s_adc_rx.md
# i2s_adc_rx

Deserialises the audio codec's I2S ADC stream (BCLK/ADCLRCK/ADCDAT, codec is master) into one signed 32-bit integer sample per frame for a selected channel. It sits directly upstream of the gain stage and drives its `sample`/`READY` inputs. It issues `READY` only while the gain stage reports idle, holds at most one pending word, and flags overruns.

## Interface
Parameters:
- `DATA_BITS`, 24: valid bits per channel word, MSB first; legal range 16..32.
- `CHANNEL`, 0: captured channel; 0 = left (LRCK low), 1 = right (LRCK high).
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronisers; minimum 2.

Ports:
- `CLK` in 1: system clock; must be at least 4× BCLK frequency.
- `RESET_N` in 1: asynchronous, active-low reset.
- `AUD_BCLK` in 1: codec bit clock, asynchronous to `CLK`.
- `AUD_ADCLRCK` in 1: codec frame/channel clock, asynchronous.
- `AUD_ADCDAT` in 1: codec serial data, asynchronous.
- `GAIN_IDLE` in 1: high when the gain stage is in IDLE and can take a sample.
- `CLR_OVERRUN` in 1: synchronous clear for `OVERRUN`.
- `sample` out 32: sign-extended captured word. Held stable between `READY` pulses.
- `READY` out 1: single-cycle strobe; `sample` is valid in the same cycle.
- `OVERRUN` out 1: sticky flag. Set when a word was overwritten before delivery.
- `frame_count` out 16: wrapping count of words delivered via `READY`.

## Operation
Input conditioning:
- All three pins pass through `SYNC_STAGES` flops.
- A BCLK rising edge (`bclk_rise`) and any LRCK transition (`lrck_edge`) are single-cycle pulses derived from the synchronised values.
- DAT is sampled only on `bclk_rise`.

State machine:
- **WAIT_FRAME**: entered on reset. Waits for an `lrck_edge` whose new LRCK level equals `CHANNEL`; then goes to SKIP with the bit counter set to 0.
- **SKIP**: the first `bclk_rise` after the edge is the I2S one-bit delay. Data is ignored and the state goes to SHIFT.
- **SHIFT**:
  - On each `bclk_rise`, shift DAT into the LSB of the shift register and increment the bit counter.
  - When the counter reaches `DATA_BITS`, load the pending register with the sign-extended word, set `pend`, and go to TAIL.
- **TAIL**: ignores trailing bits. Returns to WAIT_FRAME on the next `lrck_edge`, and evaluates that edge in the same cycle, so back-to-back frames are never missed.
- **Short frame**: an `lrck_edge` while in SKIP or SHIFT discards the partial word, with no `pend` and no `READY`. The edge is then evaluated as in WAIT_FRAME.

Delivery:
- When `pend`=1 and `GAIN_IDLE`=1: drive `sample` from the pending register, pulse `READY` for one cycle, clear `pend`, and increment `frame_count` (wraps 0xFFFF→0).
- A new word completing while `pend`=1 overwrites the pending register and sets `OVERRUN`.
- Completion and delivery in the same cycle: deliver the old word, then set `pend` with the new word. `OVERRUN` is not set.
- `CLR_OVERRUN` and an overrun event in the same cycle: set wins.

Arithmetic:
- `sample = {{(32-DATA_BITS){w[DATA_BITS-1]}}, w}`.
- When `DATA_BITS`=32 there is no extension.

## Timing
- Reset values: `sample`=0, `READY`=0, `OVERRUN`=0, `frame_count`=0, `pend`=0, state WAIT_FRAME, shift register 0.
- `RESET_N` assertion mid-word aborts immediately. After release, capture restarts at the next matching LRCK edge.
- Latency:
  - A pin edge reaches `bclk_rise` after `SYNC_STAGES`+1 CLK.
  - `pend` is set in the cycle after the `bclk_rise` of the last data bit.
  - `READY` asserts in the cycle after `pend` is set if `GAIN_IDLE`=1; otherwise it asserts in the first cycle after `GAIN_IDLE` rises.
- `READY` is never high in two consecutive cycles.
- Deassertion of `GAIN_IDLE` has no other effect.

## Structure
- Shared package `audio_pkg`:
  - `i2s_rx_state_t` enum (WAIT_FRAME, SKIP, SHIFT, TAIL).
  - `I2S_MSB_DELAY`=1.
  - `SAMPLE_W`=32.
- Sub-module `sync_edge_detect` (parameter `STAGES`; outputs `level`, `rise`, `fall`), instantiated once per pin.

## Test plan
- DATA_BITS=24, CHANNEL=0, left word 0x7FFFFF, `GAIN_IDLE`=1 → one `READY` with `sample`=0x007FFFFF, `frame_count`=1.
- Left word 0x800000 → `sample`=0xFF800000; a right word 0x123456 produces no `READY`.
- `GAIN_IDLE`=0 across word completion, raised 50 CLK later → `READY` exactly 1 cycle after the rise, `OVERRUN`=0.
- `GAIN_IDLE`=0 for two frames carrying 0x000001 then 0x000002 → `OVERRUN`=1; on release `sample`=0x00000002 with one `READY`; `CLR_OVERRUN` → 0.
- LRCK toggled after 10 data bits (short frame) → no `READY`. The next full frame carrying 0x00ABCD yields `sample`=0x0000ABCD.
- `RESET_N` pulsed low mid-SHIFT → outputs return to reset values immediately; no `READY` until the next complete left frame.
